// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded lock hold; owner's strobes muxed onto the shared bus.
// Latency: a request seen in IDLE drives the bus the next cycle; handover between masters has no idle bubble.
// Backpressure: busWaitRequest stalls the owner; the non-owner sees waitRequest high until it is granted.
module bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_LIMIT = 16
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [ADDR_WIDTH-1:0]   m0Address,
    input  logic                    m0Read,
    input  logic                    m0Write,
    input  logic [DATA_WIDTH-1:0]   m0WriteData,
    input  logic [DATA_WIDTH/8-1:0] m0ByteEnable,
    input  logic                    m0Lock,
    output logic [DATA_WIDTH-1:0]   m0ReadData,
    output logic                    m0WaitRequest,

    input  logic [ADDR_WIDTH-1:0]   m1Address,
    input  logic                    m1Read,
    input  logic                    m1Write,
    input  logic [DATA_WIDTH-1:0]   m1WriteData,
    input  logic [DATA_WIDTH/8-1:0] m1ByteEnable,
    input  logic                    m1Lock,
    output logic [DATA_WIDTH-1:0]   m1ReadData,
    output logic                    m1WaitRequest,

    output logic [ADDR_WIDTH-1:0]   busAddress,
    output logic                    busRead,
    output logic                    busWrite,
    output logic [DATA_WIDTH-1:0]   busWriteData,
    output logic [DATA_WIDTH/8-1:0] busByteEnable,
    input  logic [DATA_WIDTH-1:0]   busReadData,
    input  logic                    busWaitRequest,

    output logic [1:0]              grant
);

    localparam int              HOLD_W   = $clog2(LOCK_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LOCK_LIMIT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic [HOLD_W-1:0] r_hold_count;

    logic [1:0]        w_state_nxt;
    logic              w_last_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;

    logic w_req0;
    logic w_req1;
    logic w_own0;
    logic w_own1;
    logic w_own_req;
    logic w_own_lock;
    logic w_oth_req;
    logic w_done;
    logic w_at_limit;
    logic w_limit_rel;
    logic w_release;

    assign w_req0 = m0Read | m0Write;
    assign w_req1 = m1Read | m1Write;
    assign w_own0 = (r_state == S_OWN0);
    assign w_own1 = (r_state == S_OWN1);

    // Owner-relative view so the release rule is written once for both masters.
    assign w_own_req  = w_own1 ? w_req1 : w_req0;
    assign w_own_lock = w_own1 ? m1Lock : m0Lock;
    assign w_oth_req  = w_own1 ? w_req0 : w_req1;

    assign w_done      = (w_own0 | w_own1) & w_own_req & ~busWaitRequest;
    assign w_at_limit  = (r_hold_count == HOLD_MAX);
    assign w_limit_rel = (w_done | ~w_own_req) & w_at_limit;
    assign w_release   = (w_done & ~w_own_lock) | (~w_own_req & ~w_own_lock) | w_limit_rel;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_grant;
        w_hold_nxt  = r_hold_count;
        case (r_state)
            S_IDLE: begin
                w_hold_nxt = '0;
                if (w_req0 & w_req1) begin
                    w_state_nxt = r_last_grant ? S_OWN0 : S_OWN1;
                end else if (w_req0) begin
                    w_state_nxt = S_OWN0;
                end else if (w_req1) begin
                    w_state_nxt = S_OWN1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (w_done) begin
                    w_last_nxt = w_own1;
                end
                if (w_release) begin
                    w_hold_nxt = '0;
                    if (w_oth_req) begin
                        w_state_nxt = w_own1 ? S_OWN0 : S_OWN1;
                    end else if (w_own_req & w_limit_rel) begin
                        w_state_nxt = r_state;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (!w_at_limit) begin
                    w_hold_nxt = r_hold_count + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_hold_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_hold_count <= w_hold_nxt;
        end
    end

    always_comb begin
        busAddress    = '0;
        busRead       = 1'b0;
        busWrite      = 1'b0;
        busWriteData  = '0;
        busByteEnable = '0;
        if (w_own0) begin
            busAddress    = m0Address;
            busRead       = m0Read;
            busWrite      = m0Write;
            busWriteData  = m0WriteData;
            busByteEnable = m0ByteEnable;
        end else if (w_own1) begin
            busAddress    = m1Address;
            busRead       = m1Read;
            busWrite      = m1Write;
            busWriteData  = m1WriteData;
            busByteEnable = m1ByteEnable;
        end
    end

    assign m0WaitRequest = ~w_own0 | busWaitRequest;
    assign m1WaitRequest = ~w_own1 | busWaitRequest;
    assign m0ReadData    = busReadData;
    assign m1ReadData    = busReadData;
    assign grant         = {w_own1, w_own0};

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (lock limits 16 and 4), directed scenarios plus random traffic vs. a behavioural model.
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [AW-1:0] m0Address [2];
    logic          m0Read [2];
    logic          m0Write [2];
    logic [DW-1:0] m0WriteData [2];
    logic [BW-1:0] m0ByteEnable [2];
    logic          m0Lock [2];
    logic [DW-1:0] m0ReadData [2];
    logic          m0WaitRequest [2];
    logic [AW-1:0] m1Address [2];
    logic          m1Read [2];
    logic          m1Write [2];
    logic [DW-1:0] m1WriteData [2];
    logic [BW-1:0] m1ByteEnable [2];
    logic          m1Lock [2];
    logic [DW-1:0] m1ReadData [2];
    logic          m1WaitRequest [2];
    logic [AW-1:0] busAddress [2];
    logic          busRead [2];
    logic          busWrite [2];
    logic [DW-1:0] busWriteData [2];
    logic [BW-1:0] busByteEnable [2];
    logic [DW-1:0] busReadData [2];
    logic          busWaitRequest [2];
    logic [1:0]    grant [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bus_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .LOCK_LIMIT ((g == 0) ? 16 : 4)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .m0Address      (m0Address[g]),
            .m0Read         (m0Read[g]),
            .m0Write        (m0Write[g]),
            .m0WriteData    (m0WriteData[g]),
            .m0ByteEnable   (m0ByteEnable[g]),
            .m0Lock         (m0Lock[g]),
            .m0ReadData     (m0ReadData[g]),
            .m0WaitRequest  (m0WaitRequest[g]),
            .m1Address      (m1Address[g]),
            .m1Read         (m1Read[g]),
            .m1Write        (m1Write[g]),
            .m1WriteData    (m1WriteData[g]),
            .m1ByteEnable   (m1ByteEnable[g]),
            .m1Lock         (m1Lock[g]),
            .m1ReadData     (m1ReadData[g]),
            .m1WaitRequest  (m1WaitRequest[g]),
            .busAddress     (busAddress[g]),
            .busRead        (busRead[g]),
            .busWrite       (busWrite[g]),
            .busWriteData   (busWriteData[g]),
            .busByteEnable  (busByteEnable[g]),
            .busReadData    (busReadData[g]),
            .busWaitRequest (busWaitRequest[g]),
            .grant          (grant[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[inst%0d] at %0t: got %0h, expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    // Behavioural model: owner is -1 (nobody), 0 or 1; held counts cycles of the current grant.
    int mo_own  [2];
    int mo_last [2];
    int mo_held [2];

    task automatic model_step(input int i);
        int  lim;
        int  x;
        bit  rq [2];
        bit  lk [2];
        bit  done;
        bit  at_lim;
        bit  rel;
        lim   = (i == 0) ? 16 : 4;
        rq[0] = m0Read[i] | m0Write[i];
        rq[1] = m1Read[i] | m1Write[i];
        lk[0] = m0Lock[i];
        lk[1] = m1Lock[i];
        if (reset !== 1'b1) begin
            mo_own[i]  = -1;
            mo_last[i] = 1;
            mo_held[i] = 0;
        end else if (mo_own[i] < 0) begin
            mo_held[i] = 0;
            if (rq[0] && rq[1]) mo_own[i] = 1 - mo_last[i];
            else if (rq[0])     mo_own[i] = 0;
            else if (rq[1])     mo_own[i] = 1;
        end else begin
            x      = mo_own[i];
            done   = rq[x] && !busWaitRequest[i];
            at_lim = (mo_held[i] == lim - 1);
            if (done) mo_last[i] = x;
            rel = (done && !lk[x]) || (!rq[x] && !lk[x]) || ((done || !rq[x]) && at_lim);
            if (rel) begin
                mo_held[i] = 0;
                if (rq[1 - x])              mo_own[i] = 1 - x;
                else if (rq[x] && at_lim)   mo_own[i] = x;
                else                        mo_own[i] = -1;
            end else if (!at_lim) begin
                mo_held[i] = mo_held[i] + 1;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    logic dn0 [2];
    logic dn1 [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [AW-1:0] ea;
            logic          er, ew;
            logic [DW-1:0] ed;
            logic [BW-1:0] eb;
            int            o;
            dn0[i] = (m0Read[i] | m0Write[i]) & ~m0WaitRequest[i];
            dn1[i] = (m1Read[i] | m1Write[i]) & ~m1WaitRequest[i];
            o  = mo_own[i];
            ea = '0; er = 1'b0; ew = 1'b0; ed = '0; eb = '0;
            if (o == 0) begin
                ea = m0Address[i]; er = m0Read[i]; ew = m0Write[i]; ed = m0WriteData[i]; eb = m0ByteEnable[i];
            end else if (o == 1) begin
                ea = m1Address[i]; er = m1Read[i]; ew = m1Write[i]; ed = m1WriteData[i]; eb = m1ByteEnable[i];
            end
            if (chk_en) begin
                chk("grant",         i, grant[i],         (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00);
                chk("busAddress",    i, busAddress[i],    ea);
                chk("busRead",       i, busRead[i],       er);
                chk("busWrite",      i, busWrite[i],      ew);
                chk("busWriteData",  i, busWriteData[i],  ed);
                chk("busByteEnable", i, busByteEnable[i], eb);
                chk("m0WaitRequest", i, m0WaitRequest[i], (o != 0) || busWaitRequest[i]);
                chk("m1WaitRequest", i, m1WaitRequest[i], (o != 1) || busWaitRequest[i]);
                chk("m0ReadData",    i, m0ReadData[i],    busReadData[i]);
                chk("m1ReadData",    i, m1ReadData[i],    busReadData[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            m0Address[i] = '0; m0Read[i] = 1'b0; m0Write[i] = 1'b0; m0WriteData[i] = '0;
            m0ByteEnable[i] = '0; m0Lock[i] = 1'b0;
            m1Address[i] = '0; m1Read[i] = 1'b0; m1Write[i] = 1'b0; m1WriteData[i] = '0;
            m1ByteEnable[i] = '0; m1Lock[i] = 1'b0;
            busReadData[i] = '0; busWaitRequest[i] = 1'b0;
        end
    endtask

    task automatic gen_req(output logic rd, output logic wr, output logic [AW-1:0] a,
                           output logic [DW-1:0] d, output logic [BW-1:0] be, output logic lk);
        int k;
        k  = $urandom_range(0, 9);
        rd = (k < 5) || (k == 9);
        wr = (k >= 5);
        a  = $urandom;
        d  = $urandom;
        be = BW'($urandom);
        lk = ($urandom_range(0, 2) == 0);
    endtask

    bit act0 [2];
    bit act1 [2];

    initial begin
        reset = 1'b0;
        idle_all();
        repeat (2) step();
        chk_en = 1'b1;

        // Reset state of both instances
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_grant",    i, grant[i],          2'b00);
            chk("rst_busRead",  i, busRead[i],        1'b0);
            chk("rst_busWrite", i, busWrite[i],       1'b0);
            chk("rst_busAddr",  i, busAddress[i],     32'h0);
            chk("rst_m0Wait",   i, m0WaitRequest[i],  1'b1);
            chk("rst_m1Wait",   i, m1WaitRequest[i],  1'b1);
        end
        step();
        reset = 1'b1;

        // Single zero-wait read by m0
        m0Read[0] = 1'b1; m0Address[0] = 32'h10; busReadData[0] = 32'hCAFE0001;
        @(negedge clk);
        chk("t1_c0_grant", 0, grant[0], 2'b00);
        step();
        @(negedge clk);
        chk("t1_grant",  0, grant[0],         2'b01);
        chk("t1_rd",     0, busRead[0],       1'b1);
        chk("t1_addr",   0, busAddress[0],    32'h10);
        chk("t1_wait",   0, m0WaitRequest[0], 1'b0);
        chk("t1_rdata",  0, m0ReadData[0],    32'hCAFE0001);
        step();
        m0Read[0] = 1'b0;
        @(negedge clk);
        chk("t1_idle", 0, grant[0], 2'b00);

        // Simultaneous requests after reset, round-robin, no bubble on handover
        reset = 1'b0;
        step();
        reset = 1'b1;
        m0Read[0] = 1'b1; m0Address[0] = 32'h40; m1Read[0] = 1'b1; m1Address[0] = 32'h80;
        @(negedge clk);
        chk("t2_c0", 0, grant[0], 2'b00);
        step();
        @(negedge clk);
        chk("t2_m0_first", 0, grant[0], 2'b01);
        step();
        m0Read[0] = 1'b0;
        @(negedge clk);
        chk("t2_m1_next", 0, grant[0], 2'b10);
        chk("t2_m1_addr", 0, busAddress[0], 32'h80);
        step();
        m1Read[0] = 1'b0;
        @(negedge clk);
        chk("t2_idle", 0, grant[0], 2'b00);
        m0Read[0] = 1'b1; m1Read[0] = 1'b1;
        step();
        @(negedge clk);
        chk("t2_rr_m0", 0, grant[0], 2'b01);
        step();
        m0Read[0] = 1'b0;
        @(negedge clk);
        chk("t2_rr_m1", 0, grant[0], 2'b10);
        step();
        m1Read[0] = 1'b0;

        // m0 write stretched by 3 wait cycles while m1 waits its turn
        m0Write[0] = 1'b1; m0Address[0] = 32'h20; m0WriteData[0] = 32'h11223344; m0ByteEnable[0] = 4'hF;
        m1Read[0] = 1'b1; busWaitRequest[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) busWaitRequest[0] = 1'b0;
            @(negedge clk);
            chk("t3_grant",  0, grant[0],         2'b01);
            chk("t3_write",  0, busWrite[0],      1'b1);
            chk("t3_m1wait", 0, m1WaitRequest[0], 1'b1);
            chk("t3_m0wait", 0, m0WaitRequest[0], (c < 4) ? 1'b1 : 1'b0);
        end
        step();
        m0Write[0] = 1'b0;
        @(negedge clk);
        chk("t3_handover", 0, grant[0],         2'b10);
        chk("t3_m1go",     0, m1WaitRequest[0], 1'b0);
        step();
        m1Read[0] = 1'b0;
        @(negedge clk);
        chk("t3_idle", 0, grant[0], 2'b00);

        // m1 holds the bus with a 5-write locked burst
        m1Write[0] = 1'b1; m1Lock[0] = 1'b1; m1Address[0] = 32'h100; m1WriteData[0] = 32'h0;
        step();
        m0Read[0] = 1'b1; m0Address[0] = 32'h200;
        for (int w = 1; w <= 5; w++) begin
            @(negedge clk);
            chk("t4_locked", 0, grant[0],         2'b10);
            chk("t4_m0wait", 0, m0WaitRequest[0], 1'b1);
            step();
            if (w < 5) begin
                m1Address[0]   = 32'h100 + 32'(4 * w);
                m1WriteData[0] = 32'(w);
                m1Lock[0]      = (w < 4);
            end
        end
        m1Write[0] = 1'b0; m1Lock[0] = 1'b0;
        @(negedge clk);
        chk("t4_to_m0", 0, grant[0],      2'b01);
        chk("t4_addr",  0, busAddress[0], 32'h200);
        step();
        m0Read[0] = 1'b0;
        @(negedge clk);
        chk("t4_idle", 0, grant[0], 2'b00);

        // Lock limit of 4 on instance 1 forces release to a waiting m1
        m0Read[1] = 1'b1; m0Lock[1] = 1'b1; m0Address[1] = 32'h0; m1Read[1] = 1'b1; m1Address[1] = 32'h500;
        step();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t5_m0_held", 1, grant[1], 2'b01);
            step();
            m0Address[1] = 32'(4 * c);
        end
        m0Read[1] = 1'b0; m0Lock[1] = 1'b0;
        @(negedge clk);
        chk("t5_limit_rel", 1, grant[1],      2'b10);
        chk("t5_addr",      1, busAddress[1], 32'h500);
        step();
        m1Read[1] = 1'b0;
        @(negedge clk);
        chk("t5_idle", 1, grant[1], 2'b00);

        // Reset in the middle of a waited m1 read
        m1Read[0] = 1'b1; m1Address[0] = 32'h300; busWaitRequest[0] = 1'b1;
        step();
        @(negedge clk);
        chk("t6_m1_own",  0, grant[0],         2'b10);
        chk("t6_m1_wait", 0, m1WaitRequest[0], 1'b1);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_sync", 0, grant[0], 2'b10);
        step();
        @(negedge clk);
        chk("t6_grant", 0, grant[0],         2'b00);
        chk("t6_rd",    0, busRead[0],       1'b0);
        chk("t6_addr",  0, busAddress[0],    32'h0);
        chk("t6_w0",    0, m0WaitRequest[0], 1'b1);
        chk("t6_w1",    0, m1WaitRequest[0], 1'b1);
        step();
        reset = 1'b1;
        m0Read[0] = 1'b1; m0Address[0] = 32'h400; busWaitRequest[0] = 1'b0;
        @(negedge clk);
        chk("t6_c0", 0, grant[0], 2'b00);
        step();
        @(negedge clk);
        chk("t6_m0_prio", 0, grant[0], 2'b01);
        step();
        m0Read[0] = 1'b0;
        @(negedge clk);
        chk("t6_m1_after", 0, grant[0], 2'b10);
        step();
        m1Read[0] = 1'b0;

        // Random traffic on both instances
        for (int i = 0; i < 2; i++) begin
            act0[i] = 1'b0;
            act1[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            reset = ($urandom_range(0, 599) != 0);
            for (int i = 0; i < 2; i++) begin
                logic          rd, wr, lk;
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                logic [BW-1:0] be;
                busWaitRequest[i] = ($urandom_range(0, 2) == 0);
                busReadData[i]    = $urandom;
                if (act0[i] && dn0[i]) act0[i] = 1'b0;
                if (act1[i] && dn1[i]) act1[i] = 1'b0;
                if (!act0[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        gen_req(rd, wr, a, d, be, lk);
                        m0Read[i] = rd; m0Write[i] = wr; m0Address[i] = a;
                        m0WriteData[i] = d; m0ByteEnable[i] = be; m0Lock[i] = lk;
                        act0[i] = 1'b1;
                    end else begin
                        m0Read[i] = 1'b0; m0Write[i] = 1'b0;
                        m0Lock[i] = ($urandom_range(0, 3) == 0);
                    end
                end
                if (!act1[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        gen_req(rd, wr, a, d, be, lk);
                        m1Read[i] = rd; m1Write[i] = wr; m1Address[i] = a;
                        m1WriteData[i] = d; m1ByteEnable[i] = be; m1Lock[i] = lk;
                        act1[i] = 1'b1;
                    end else begin
                        m1Read[i] = 1'b0; m1Write[i] = 1'b0;
                        m1Lock[i] = ($urandom_range(0, 3) == 0);
                    end
                end
            end
        end
        reset = 1'b1;
        idle_all();
        repeat (3) step();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
